// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: opcodes, ALU ops, instruction field positions
// and the mult/div occupancy state type.
package pipe_pkg;

    localparam int OPC_W   = 5;
    localparam int ALUOP_W = 5;

    localparam logic [OPC_W-1:0]   OP_RTYPE = 5'b00000;
    localparam logic [OPC_W-1:0]   OP_LW    = 5'b01000;
    localparam logic [OPC_W-1:0]   OP_SW    = 5'b00111;
    localparam logic [ALUOP_W-1:0] ALU_MULT = 5'b00110;
    localparam logic [ALUOP_W-1:0] ALU_DIV  = 5'b00111;

    // Field positions for the default 32-bit instruction with 5-bit specifiers.
    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int ALUOP_LSB = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} md_state_t;

endpackage

// File: rtl/md_tracker.sv
// Mult/div occupancy FSM: launch strobe, latency watchdog and sticky timeout.
module md_tracker
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = 34
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      dx_md,
    input  logic      dx_div,
    input  logic      flush,
    input  logic      multdiv_result_ready,
    output md_state_t md_state,
    output logic      md_start,
    output logic      md_is_div,
    output logic      md_busy,
    output logic      md_timeout
);

    localparam logic [7:0] LAT_M1 = 8'(MD_LATENCY - 1);

    md_state_t  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       div_q, div_d;
    logic       tmo_q, tmo_d;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first so no branch leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (dx_md && !flush) begin
                    state_d = ISSUE;
                    div_d   = dx_div;
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = BUSY;
                    cnt_d   = LAT_M1;
                end
            end
            BUSY: begin
                // A result arriving on the expiry cycle still counts as success.
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (multdiv_result_ready) begin
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign md_state   = state_q;
    assign md_start   = (state_q == ISSUE);
    assign md_is_div  = div_q;
    assign md_busy    = (state_q != IDLE);
    assign md_timeout = tmo_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use detect, multdiv stall, freeze/bubble muxing.
// Define HAZARD_PERF_EN to build the saturating stall performance counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int INSTR_W     = 32,
    parameter int REG_W       = 5,
    parameter int MD_LATENCY  = 34,
    parameter int LOAD_STAGES = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] fd_ir,
    input  logic [INSTR_W-1:0] dx_ir,
    input  logic [INSTR_W-1:0] xm_ir,
    input  logic               flush,
    input  logic               multdiv_result_ready,
    output logic               stall_fd,
    output logic               bubble_dx,
    output logic               md_start,
    output logic               md_is_div,
    output logic               md_busy,
    output logic               md_timeout,
    output logic [31:0]        perf_lu_stalls,
    output logic [31:0]        perf_md_stalls
);

    function automatic logic [OPC_W-1:0] opc(input logic [INSTR_W-1:0] ir);
        return ir[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [REG_W-1:0] fld(input logic [INSTR_W-1:0] ir, input int lsb);
        return ir[lsb +: REG_W];
    endfunction

    // A load writing a nonzero rd that the consumer reads (rt is data, not a source, for sw).
    function automatic logic load_hit(input logic [INSTR_W-1:0] ld, input logic [INSTR_W-1:0] user);
        logic [REG_W-1:0] dst;
        dst = fld(ld, RD_LSB);
        return (opc(ld) == OP_LW) && (dst != '0) &&
               ((fld(user, RS_LSB) == dst) ||
                ((fld(user, RT_LSB) == dst) && (opc(user) != OP_SW)));
    endfunction

    logic       lu_dx, lu_xm, lu;
    logic       dx_md, dx_div, md_stall;
    md_state_t  md_state;
    logic       unused_ir;

    assign lu_dx = load_hit(dx_ir, fd_ir);
    assign lu_xm = (LOAD_STAGES == 2) && load_hit(xm_ir, fd_ir);
    assign lu    = lu_dx | lu_xm;

    assign dx_div = (opc(dx_ir) == OP_RTYPE) && (dx_ir[ALUOP_LSB +: ALUOP_W] == ALU_DIV);
    assign dx_md  = dx_div ||
                    ((opc(dx_ir) == OP_RTYPE) && (dx_ir[ALUOP_LSB +: ALUOP_W] == ALU_MULT));

    assign unused_ir = ^{fd_ir, dx_ir, xm_ir};

    md_tracker #(.MD_LATENCY(MD_LATENCY)) u_md_tracker (
        .clock                (clock),
        .reset                (reset),
        .dx_md                (dx_md),
        .dx_div               (dx_div),
        .flush                (flush),
        .multdiv_result_ready (multdiv_result_ready),
        .md_state             (md_state),
        .md_start             (md_start),
        .md_is_div            (md_is_div),
        .md_busy              (md_busy),
        .md_timeout           (md_timeout)
    );

    // The detect cycle in IDLE already stalls; DONE releases the op to X/M.
    assign md_stall  = dx_md && (md_state != DONE);
    assign stall_fd  = (lu || md_stall) && !flush;
    assign bubble_dx = lu && !md_stall && !flush;

`ifdef HAZARD_PERF_EN
    logic [31:0] lu_cnt_q, md_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            lu_cnt_q <= '0;
            md_cnt_q <= '0;
        end else begin
            if (stall_fd && lu && !md_stall && (lu_cnt_q != '1))
                lu_cnt_q <= lu_cnt_q + 32'd1;
            if (stall_fd && md_stall && (md_cnt_q != '1))
                md_cnt_q <= md_cnt_q + 32'd1;
        end
    end

    assign perf_lu_stalls = lu_cnt_q;
    assign perf_md_stalls = md_cnt_q;
`else
    assign perf_lu_stalls = '0;
    assign perf_md_stalls = '0;
`endif

endmodule
